matrix_storage_arbiter: RTL
===========================

Name: matrix_storage_arbiter

Overview:
- Shares the single matrix storage block between three requesters: operation result writer (req 0), user matrix input (req 1) and display/readout (req 2).
- Grants one requester at a time, validates its matrix dimensions, and issues the storage start pulse.
- Counts element beats until m*n have been transferred, then releases the grant.
- Aborts stalled or withdrawn transfers with an error pulse.
- Sits between the UART/keypad front end, the ALU result path and the storage block.

Parameters:
NUM_REQ, 3, number of requesters; index 0 has highest fixed priority.
MAX_DIM, 5, largest legal row/column count; legal range 1..MAX_DIM.
TIMEOUT_CYCLES, 255, idle cycles allowed between beats during a transfer before abort.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  level request per requester; held until transfer ends
req_m  input  3*NUM_REQ  packed row counts; requester k uses bits [3k+2:3k]
req_n  input  3*NUM_REQ  packed column counts; same packing
beat  input  NUM_REQ  per-requester element strobe, one per element
gnt  output  NUM_REQ  one-hot grant, registered
start_pulse  output  1  single-cycle start to storage
sel_id  output  2  index of granted requester
sel_m  output  3  latched rows of granted transfer
sel_n  output  3  latched columns of granted transfer
beat_out  output  1  granted requester's beat, forwarded combinationally and gated by grant
elem_cnt  output  5  beats accepted in current transfer
busy  output  1  high in every state other than IDLE
done_pulse  output  1  single-cycle pulse on normal completion
dim_err  output  1  single-cycle pulse on illegal dimensions
abort_err  output  1  single-cycle pulse on timeout or withdrawn request

Behaviour:
- Reset values: all outputs 0, state IDLE, reject mask 0, timeout counter 0, round-robin pointer 0. Reset mid-transfer drops gnt immediately; no done or error pulses are issued.
- Eligible requests: req & ~mask. A mask bit is set when that requester is rejected for illegal dimensions. The bit clears when that req deasserts.
- IDLE: if any eligible request exists, pick the winner (fixed priority, lowest index wins) and latch sel_id, sel_m and sel_n from the winner's fields.
  - If m or n is 0 or greater than MAX_DIM: dim_err=1 for one cycle, set the winner's mask bit, stay in IDLE. No grant is issued.
  - Otherwise: go to GRANT.
- GRANT (1 cycle): gnt[sel_id]=1, start_pulse=1, elem_cnt=0, timeout counter=0 → XFER.
- XFER:
  - Each cycle with beat[sel_id]=1: elem_cnt+1, timeout counter cleared.
  - When the accepted beat makes elem_cnt equal sel_m*sel_n (6-bit product, maximum 25) → DONE.
  - Beats from non-granted requesters are ignored and never forwarded.
  - No beat for TIMEOUT_CYCLES consecutive cycles: abort_err pulse, gnt=0 → IDLE.
  - req[sel_id] deasserts: abort_err pulse, gnt=0 → IDLE. If this coincides with the final beat, completion wins → DONE.
- DONE (1 cycle): done_pulse=1; gnt is cleared at the end of the cycle → IDLE.
- Re-arbitration: the next grant is issued no earlier than the cycle after return to IDLE, so there is at least one idle cycle between grants.
- Latency: request seen in IDLE → gnt and start_pulse asserted 2 cycles later. Last beat → done_pulse next cycle.
- A requester that still holds req after DONE is granted again on the next arbitration. Requesters must deassert req once their done_pulse is observed.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: the winner is the first eligible requester at or after (last granted index + 1) mod NUM_REQ. The pointer updates only on DONE or abort, not on dim_err.
- Undefined: fixed priority, index 0 highest. No pointer register exists.

Test Plan:
- req=3'b010, m=2, n=3, then 6 beats on beat[1] → gnt=3'b010 and start_pulse 2 cycles after req; elem_cnt reaches 6; done_pulse 1 cycle after the 6th beat; gnt then returns to 0.
- req=3'b111 simultaneously, all with 1x1 dims, fixed priority → grants in order 0, 1, 2, each after the prior done. With ARB_ROUND_ROBIN_EN and last grant=0, req 0 and 2 re-raised → order 1, 2, 0.
- req[2]=1 with m=0, n=4 → dim_err single pulse, no gnt, no repeat pulse while req[2] stays high. Deassert, then reassert with m=4 → granted.
- Granted 3x3 transfer, 4 beats then silence for 255 cycles → abort_err pulse at cycle 255, gnt=0, busy=0.
- Granted 5x5 transfer, beat[0] toggling while req[1] granted → beat_out stays 0 and elem_cnt is unaffected. Assert rst_n=0 at elem_cnt=10 → all outputs 0 asynchronously, no pulses.

Source files
------------

// File: rtl/matrix_storage_arbiter_if.sv
// Bundle of request, dimension, beat and grant/status signals between the
// three matrix storage requesters and the storage arbiter.
interface matrix_storage_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]   req;
    logic [3*NUM_REQ-1:0] req_m;
    logic [3*NUM_REQ-1:0] req_n;
    logic [NUM_REQ-1:0]   beat;

    logic [NUM_REQ-1:0]   gnt;
    logic                 start_pulse;
    logic [IDW-1:0]       sel_id;
    logic [2:0]           sel_m;
    logic [2:0]           sel_n;
    logic                 beat_out;
    logic [4:0]           elem_cnt;
    logic                 busy;
    logic                 done_pulse;
    logic                 dim_err;
    logic                 abort_err;

    // Requester side: drives requests and beats, observes grant and status.
    modport master (
        output req, req_m, req_n, beat,
        input  gnt, start_pulse, sel_id, sel_m, sel_n, beat_out,
        input  elem_cnt, busy, done_pulse, dim_err, abort_err
    );

    // Arbiter side.
    modport slave (
        input  req, req_m, req_n, beat,
        output gnt, start_pulse, sel_id, sel_m, sel_n, beat_out,
        output elem_cnt, busy, done_pulse, dim_err, abort_err
    );
endinterface

// File: rtl/matrix_storage_arbiter.sv
// Arbitrates the shared matrix storage block between NUM_REQ requesters.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority otherwise.
module matrix_storage_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int MAX_DIM        = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                   clk,
    input logic                   rst_n,
    matrix_storage_arbiter_if.slave bus
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    MAX_DIM_L = 3'(MAX_DIM);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        XFER,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] mask_q, mask_d;
    logic [IDW-1:0]     selId_q, selId_d;
    logic [2:0]         selM_q, selM_d;
    logic [2:0]         selN_q, selN_d;
    logic [4:0]         elemCnt_q, elemCnt_d;
    logic [TW-1:0]      toCnt_q, toCnt_d;
    logic               start_q, start_d;
    logic               done_q, done_d;
    logic               dimErr_q, dimErr_d;
    logic               abortErr_q, abortErr_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic [IDW-1:0]     ptr_q, ptr_d;
    int                 rrIdx;
`endif

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] selOneHot;
    logic               found;
    logic [IDW-1:0]     winId;
    logic [2:0]         winM;
    logic [2:0]         winN;
    logic               winLegal;
    logic               beatSel;
    logic               reqSel;
    logic [5:0]         product;

    assign selOneHot = NUM_REQ'(1) << selId_q;
    assign beatSel   = |(bus.beat & selOneHot);
    assign reqSel    = |(bus.req & selOneHot);
    assign product   = {3'b000, selM_q} * {3'b000, selN_q};
    assign winLegal  = (winM != 3'd0) && (winM <= MAX_DIM_L) &&
                       (winN != 3'd0) && (winN <= MAX_DIM_L);

    // Winner selection among requesters not blocked by an earlier dimension reject.
    always_comb begin
        elig  = bus.req & ~mask_q;
        found = 1'b0;
        winId = '0;
        winM  = '0;
        winN  = '0;
`ifdef ARB_ROUND_ROBIN_EN
        rrIdx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rrIdx = (int'(ptr_q) + 1 + k) % NUM_REQ;
            if (!found && elig[rrIdx]) begin
                found = 1'b1;
                winId = IDW'(rrIdx);
                winM  = bus.req_m[3*rrIdx +: 3];
                winN  = bus.req_n[3*rrIdx +: 3];
            end
        end
`else
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && elig[k]) begin
                found = 1'b1;
                winId = IDW'(k);
                winM  = bus.req_m[3*k +: 3];
                winN  = bus.req_n[3*k +: 3];
            end
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        mask_d     = mask_q & bus.req;
        selId_d    = selId_q;
        selM_d     = selM_q;
        selN_d     = selN_q;
        elemCnt_d  = elemCnt_q;
        toCnt_d    = toCnt_q;
        start_d    = 1'b0;
        done_d     = 1'b0;
        dimErr_d   = 1'b0;
        abortErr_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    selId_d = winId;
                    selM_d  = winM;
                    selN_d  = winN;
                    if (!winLegal) begin
                        dimErr_d = 1'b1;
                        mask_d   = mask_d | (NUM_REQ'(1) << winId);
                    end else begin
                        state_d = GRANT;
                    end
                end
            end
            GRANT: begin
                gnt_d     = selOneHot;
                start_d   = 1'b1;
                elemCnt_d = '0;
                toCnt_d   = '0;
                state_d   = XFER;
            end
            XFER: begin
                // A completing beat takes precedence over a withdrawn request.
                if (beatSel && (({1'b0, elemCnt_q} + 6'd1) == product)) begin
                    elemCnt_d = elemCnt_q + 5'd1;
                    toCnt_d   = '0;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else if (!reqSel || (!beatSel && toCnt_q == TO_LAST)) begin
                    abortErr_d = 1'b1;
                    gnt_d      = '0;
                    state_d    = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d      = selId_q;
`endif
                end else if (beatSel) begin
                    elemCnt_d = elemCnt_q + 5'd1;
                    toCnt_d   = '0;
                end else begin
                    toCnt_d = toCnt_q + 1'b1;
                end
            end
            DONE: begin
                gnt_d   = '0;
                state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                ptr_d   = selId_q;
`endif
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            mask_q     <= '0;
            selId_q    <= '0;
            selM_q     <= '0;
            selN_q     <= '0;
            elemCnt_q  <= '0;
            toCnt_q    <= '0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            dimErr_q   <= 1'b0;
            abortErr_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            mask_q     <= mask_d;
            selId_q    <= selId_d;
            selM_q     <= selM_d;
            selN_q     <= selN_d;
            elemCnt_q  <= elemCnt_d;
            toCnt_q    <= toCnt_d;
            start_q    <= start_d;
            done_q     <= done_d;
            dimErr_q   <= dimErr_d;
            abortErr_q <= abortErr_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.start_pulse = start_q;
    assign bus.sel_id      = selId_q;
    assign bus.sel_m       = selM_q;
    assign bus.sel_n       = selN_q;
    assign bus.beat_out    = |(bus.beat & gnt_q);
    assign bus.elem_cnt    = elemCnt_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done_pulse  = done_q;
    assign bus.dim_err     = dimErr_q;
    assign bus.abort_err   = abortErr_q;
endmodule
